// File: rtl/battleship_pkg.sv
// Shared Battleship types: board geometry, cell encoding and PC attacker state codes.
package battleship_pkg;

   localparam int DIM     = 5;
   localparam int N_CELLS = DIM * DIM;

   typedef enum logic [1:0] {
      CELL_WATER = 2'b00,
      CELL_SHIP  = 2'b01,
      CELL_MISS  = 2'b10,
      CELL_HIT   = 2'b11
   } cell_t;

   typedef enum logic [1:0] {
      PC_IDLE   = 2'd0,
      PC_SEARCH = 2'd1,
      PC_WRITE  = 2'd2,
      PC_DONE   = 2'd3
   } pc_atk_state_t;

endpackage

// File: rtl/pc_attacker_if.sv
// Board access and game-FSM signals of the PC attacker; slave is the attacker side.
interface pc_attacker_if;
   import battleship_pkg::*;

   logic       start;
   logic [2:0] ships_total;
   logic [2:0] rd_i;
   logic [2:0] rd_j;
   logic [1:0] rd_data;
   logic       wr_en;
   logic [2:0] wr_i;
   logic [2:0] wr_j;
   logic [1:0] wr_data;
   logic       busy;
   logic       done;
   logic       hit;
   logic [2:0] shot_i;
   logic [2:0] shot_j;
   logic [2:0] hit_count;
   logic       all_sunk;
   logic       no_target;

   modport slave (
      input  start, ships_total, rd_data,
      output rd_i, rd_j, wr_en, wr_i, wr_j, wr_data, busy, done, hit,
             shot_i, shot_j, hit_count, all_sunk, no_target
   );

   modport master (
      output start, ships_total, rd_data,
      input  rd_i, rd_j, wr_en, wr_i, wr_j, wr_data, busy, done, hit,
             shot_i, shot_j, hit_count, all_sunk, no_target
   );

endinterface

// File: rtl/lfsr5.sv
// 5-bit Fibonacci LFSR, x^5+x^3+1, period 31; seed must be non-zero.
module lfsr5 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [4:0] seed,
   output logic [4:0] q
);

   always_ff @(posedge clk) begin
      if (!rst)
         q <= seed;
      else if (en)
         q <= {q[3:0], q[4] ^ q[2]};
   end

endmodule

// File: rtl/pc_attacker.sv
// PC opponent shot engine: picks a pseudo-random unshot player cell, marks it HIT/MISS.
//  state  | meaning
//  IDLE   | waiting for start
//  SEARCH | probing LFSR candidates until a shootable cell is found
//  WRITE  | one-cycle write of HIT/MISS to the player board
//  DONE   | one-cycle done pulse with the shot result
module pc_attacker
   import battleship_pkg::*;
#(
   parameter logic [4:0] SEED = 5'b00001
) (
   input  logic          clk,
   input  logic          rst,
   pc_attacker_if.slave  bus
);

   localparam logic [1:0] S_IDLE   = PC_IDLE;
   localparam logic [1:0] S_SEARCH = PC_SEARCH;
   localparam logic [1:0] S_WRITE  = PC_WRITE;
   localparam logic [1:0] S_DONE   = PC_DONE;
   localparam logic [4:0] CELLS    = 5'(N_CELLS);

   logic [1:0] state;
   logic [4:0] lfsr;
   logic [4:0] k;
   logic [5:0] cand_ij;
   logic       cand_ok;
   logic       take;
   logic [4:0] shots_fired;
   logic [2:0] hit_count;
   logic       is_ship;
   logic [2:0] shot_i;
   logic [2:0] shot_j;

   lfsr5 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .en   (state == S_SEARCH),
      .seed (SEED),
      .q    (lfsr)
   );

   assign k       = lfsr - 5'd1;
   assign cand_ok = (k < CELLS);

   // Octal literal holds {row, col}; out-of-range indices fall to (0,0) and are never taken.
   always_comb begin
      cand_ij = 6'o00;
      case (k)
         5'd0:  cand_ij = 6'o00;  5'd1:  cand_ij = 6'o01;  5'd2:  cand_ij = 6'o02;
         5'd3:  cand_ij = 6'o03;  5'd4:  cand_ij = 6'o04;  5'd5:  cand_ij = 6'o10;
         5'd6:  cand_ij = 6'o11;  5'd7:  cand_ij = 6'o12;  5'd8:  cand_ij = 6'o13;
         5'd9:  cand_ij = 6'o14;  5'd10: cand_ij = 6'o20;  5'd11: cand_ij = 6'o21;
         5'd12: cand_ij = 6'o22;  5'd13: cand_ij = 6'o23;  5'd14: cand_ij = 6'o24;
         5'd15: cand_ij = 6'o30;  5'd16: cand_ij = 6'o31;  5'd17: cand_ij = 6'o32;
         5'd18: cand_ij = 6'o33;  5'd19: cand_ij = 6'o34;  5'd20: cand_ij = 6'o40;
         5'd21: cand_ij = 6'o41;  5'd22: cand_ij = 6'o42;  5'd23: cand_ij = 6'o43;
         5'd24: cand_ij = 6'o44;
         default: cand_ij = 6'o00;
      endcase
   end

   assign take = (state == S_SEARCH) && cand_ok && !bus.rd_data[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= S_IDLE;
         shots_fired <= '0;
         hit_count   <= '0;
         is_ship     <= 1'b0;
         shot_i      <= '0;
         shot_j      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (shots_fired == CELLS) begin
                     is_ship <= 1'b0;
                     state   <= S_DONE;
                  end else begin
                     state <= S_SEARCH;
                  end
               end
            end
            S_SEARCH: begin
               if (take) begin
                  shot_i  <= cand_ij[5:3];
                  shot_j  <= cand_ij[2:0];
                  is_ship <= (bus.rd_data == CELL_SHIP);
                  state   <= S_WRITE;
               end
            end
            S_WRITE: begin
               shots_fired <= shots_fired + 5'd1;
               if (is_ship && hit_count != 3'd7)
                  hit_count <= hit_count + 3'd1;
               state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.rd_i      = (state == S_SEARCH) ? cand_ij[5:3] : 3'd0;
   assign bus.rd_j      = (state == S_SEARCH) ? cand_ij[2:0] : 3'd0;
   // Gate with rst so a reset landing in WRITE keeps the board untouched.
   assign bus.wr_en     = (state == S_WRITE) && rst;
   assign bus.wr_i      = shot_i;
   assign bus.wr_j      = shot_j;
   assign bus.wr_data   = is_ship ? CELL_HIT : CELL_MISS;
   assign bus.busy      = (state != S_IDLE);
   assign bus.done      = (state == S_DONE);
   assign bus.hit       = is_ship;
   assign bus.shot_i    = shot_i;
   assign bus.shot_j    = shot_j;
   assign bus.hit_count = hit_count;
   assign bus.all_sunk  = (hit_count == bus.ships_total) && (bus.ships_total != 3'd0);
   assign bus.no_target = (shots_fired == CELLS);

endmodule

// File: tb/tb_pc_attacker.sv
// Scoreboard bench for pc_attacker: directed shots, expected results queued at issue time.
module tb_pc_attacker;
   import battleship_pkg::*;

   typedef struct {
      logic [2:0] i;
      logic [2:0] j;
      logic       hit;
      logic       nt;
      logic       chk_coords;
      int         issue;
      int         lat;
   } done_exp_t;

   typedef struct {
      logic [2:0] i;
      logic [2:0] j;
      logic [1:0] d;
   } wr_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pc_attacker_if bif ();

   pc_attacker #(.SEED(5'b00001)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   done_exp_t  dq[$];
   wr_exp_t    wq[$];
   int         checks   = 0;
   int         passes   = 0;
   int         cyc      = 0;
   int         done_cnt = 0;
   int         wr_cnt   = 0;
   logic [1:0] board [25];
   int         wcnt  [25];
   logic       board_clr = 1'b0;
   logic       cfg_we    = 1'b0;
   int         cfg_k     = 0;
   logic [1:0] cfg_d     = 2'b00;

   // Order in which a fresh board gets shot from SEED=1 (k>=25 candidates dropped).
   int seq [25] = '{0, 1, 3, 8, 17, 4, 10, 21, 11, 24, 18, 6, 14,
                    23, 16, 2, 5, 12, 22, 13, 20, 9, 19, 7, 15};

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      bif.rd_data = 2'b00;
      if (bif.rd_i < 3'd5 && bif.rd_j < 3'd5)
         bif.rd_data = board[int'(bif.rd_i) * 5 + int'(bif.rd_j)];
   end

   always @(posedge clk) begin
      if (board_clr) begin
         for (int n = 0; n < 25; n++) begin
            board[n] <= 2'b00;
            wcnt[n]  <= 0;
         end
      end else if (cfg_we) begin
         board[cfg_k] <= cfg_d;
      end
      if (bif.wr_en && bif.wr_i < 3'd5 && bif.wr_j < 3'd5) begin
         board[int'(bif.wr_i) * 5 + int'(bif.wr_j)] <= bif.wr_data;
         wcnt[int'(bif.wr_i) * 5 + int'(bif.wr_j)]  <= wcnt[int'(bif.wr_i) * 5 + int'(bif.wr_j)] + 1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      done_exp_t de;
      wr_exp_t   we;
      forever begin
         @(negedge clk);
         if (bif.wr_en) begin
            wr_cnt++;
            check("write_expected", int'(wq.size() > 0), 1);
            if (wq.size() > 0) begin
               we = wq.pop_front();
               check("wr_i", bif.wr_i, we.i);
               check("wr_j", bif.wr_j, we.j);
               check("wr_data", bif.wr_data, we.d);
            end
         end
         if (bif.done) begin
            done_cnt++;
            check("done_expected", int'(dq.size() > 0), 1);
            if (dq.size() > 0) begin
               de = dq.pop_front();
               if (de.chk_coords) begin
                  check("shot_i", bif.shot_i, de.i);
                  check("shot_j", bif.shot_j, de.j);
                  check("hit", bif.hit, de.hit);
               end
               check("no_target_at_done", bif.no_target, de.nt);
               if (de.lat >= 0) check("done_latency", cyc - de.issue, de.lat);
            end
         end
      end
   end

   task automatic set_cell(input int k, input logic [1:0] d);
      cfg_k  = k;
      cfg_d  = d;
      cfg_we = 1'b1;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic clear_board();
      board_clr = 1'b1;
      step();
      board_clr = 1'b0;
   endtask

   task automatic fire(input int k, input bit hit, input bit nt, input int lat,
                       input int hold, input bit wr);
      done_exp_t de;
      wr_exp_t   we;
      int        d0;
      step();
      d0            = done_cnt;
      de.i          = 3'(k / 5);
      de.j          = 3'(k % 5);
      de.hit        = hit;
      de.nt         = nt;
      de.chk_coords = wr;
      de.issue      = cyc;
      de.lat        = lat;
      dq.push_back(de);
      if (wr) begin
         we.i = 3'(k / 5);
         we.j = 3'(k % 5);
         we.d = hit ? 2'b11 : 2'b10;
         wq.push_back(we);
      end
      bif.start = 1'b1;
      repeat (hold) step();
      bif.start = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (done_cnt != d0) break;
         step();
      end
      check("shot_completed", int'(done_cnt != d0), 1);
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, bif.busy, 0);
      check({tag, "_done"}, bif.done, 0);
      check({tag, "_wr_en"}, bif.wr_en, 0);
      check({tag, "_hit"}, bif.hit, 0);
      check({tag, "_no_target"}, bif.no_target, 0);
      check({tag, "_shot_i"}, bif.shot_i, 0);
      check({tag, "_shot_j"}, bif.shot_j, 0);
      check({tag, "_hit_count"}, bif.hit_count, 0);
      check({tag, "_rd_i"}, bif.rd_i, 0);
      check({tag, "_rd_j"}, bif.rd_j, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passes, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int d0;
      bif.start       = 1'b0;
      bif.ships_total = 3'd0;
      rst             = 1'b0;
      board_clr       = 1'b1;
      repeat (3) step();
      board_clr = 1'b0;
      check_reset_outputs("reset");
      check("reset_all_sunk", bif.all_sunk, 0);

      rst             = 1'b1;
      bif.ships_total = 3'd1;
      step();

      // Shot 1: all water, LFSR=1 -> (0,0) MISS at t+3
      fire(0, 1'b0, 1'b0, 3, 1, 1'b1);
      check("t1_hit_count", bif.hit_count, 0);
      check("t1_all_sunk", bif.all_sunk, 0);

      // Shot 2: LFSR=2 -> (0,1), ship there
      set_cell(1, 2'b01);
      fire(1, 1'b1, 1'b0, 3, 1, 1'b1);
      check("t2_hit_count", bif.hit_count, 1);
      check("t2_all_sunk", bif.all_sunk, 1);

      // Shot 3: (0,3) pre-marked, LFSR=4 rejected, LFSR=9 -> (1,3); start held through SEARCH
      set_cell(2, 2'b10);
      set_cell(3, 2'b10);
      w0 = wr_cnt;
      d0 = done_cnt;
      fire(8, 1'b0, 1'b0, 4, 3, 1'b1);
      repeat (3) step();
      check("t3_writes_per_shot", wr_cnt - w0, 1);
      check("t3_dones_per_shot", done_cnt - d0, 1);
      check("t3_skipped_cell_unwritten", wcnt[3], 0);
      check("t3_hit_count", bif.hit_count, 1);

      // Reset during WRITE of the next shot (LFSR=18 -> (3,2))
      step();
      bif.start = 1'b1;
      step();
      bif.start = 1'b0;
      step();
      rst = 1'b0;
      step();
      check_reset_outputs("midshot_reset");
      check("midshot_no_write", wcnt[17], 0);
      clear_board();
      rst = 1'b1;
      step();

      // Full game on a fresh board: ships at (0,1), (1,3), (4,4)
      set_cell(1, 2'b01);
      set_cell(8, 2'b01);
      set_cell(24, 2'b01);
      bif.ships_total = 3'd3;
      for (int n = 0; n < 25; n++) begin
         fire(seq[n], (seq[n] == 1 || seq[n] == 8 || seq[n] == 24), (n == 24),
              (n == 0) ? 3 : -1, 1, 1'b1);
      end
      check("t4_hit_count", bif.hit_count, 3);
      check("t4_all_sunk", bif.all_sunk, 1);
      check("t4_no_target", bif.no_target, 1);
      for (int n = 0; n < 25; n++) check($sformatf("t4_writes_cell%0d", n), wcnt[n], 1);

      // 26th start: immediate done, no write
      w0 = wr_cnt;
      fire(0, 1'b0, 1'b1, 1, 1, 1'b0);
      repeat (2) step();
      check("t4_no_extra_write", wr_cnt - w0, 0);
      check("t4_idle_after", bif.busy, 0);

      check("done_queue_drained", dq.size(), 0);
      check("write_queue_drained", wq.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
